// File: rtl/reaction_pkg.sv
// Shared types and constants for the multi-player reaction timer.
//   state_e  : round FSM states, in round order
//   res_e    : per-player round result
//   ALL_ONES : wide all-ones constant; slice it to any counter width
package reaction_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StStim,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        ResNone,
        ResValid,
        ResCheat,
        ResSlow
    } res_e;

    localparam logic [63:0] ALL_ONES = '1;

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond tick generator.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset, clears the divider
//   tick_o : one-cycle pulse every TICK_DIV clock cycles
module ms_tick_gen #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int unsigned CntW = $clog2(TICK_DIV);
    localparam logic [CntW-1:0] LastCnt = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LastCnt);
    assign cnt_d  = tick_o ? '0 : cnt_q + CntW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reaction_timer_nch.sv
// N-player reaction timer. A start edge arms a random delay; the stimulus LED then
// lights and each player's first stop edge latches a millisecond response time.
//   clk, reset_n       : clock, asynchronous active-low reset
//   start, stop        : raw asynchronous buttons (synchronised, rising edges act)
//   clear_best         : synchronous pulse, resets best_time to all ones
//   rand_in            : random extra delay in ms
//   stim_led, busy     : state indicators
//   times              : per-player latched time, player p at [p*CNT_W +: CNT_W]
//   valid/cheat/slow   : per-player result flags
//   winner(_valid)     : fastest valid player, lowest index on ties
//   best_time          : best winner time since reset or clear_best
module reaction_timer_nch
    import reaction_pkg::*;
#(
    parameter int unsigned N_PLAYERS    = 2,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned MAX_MS       = 1000,
    parameter int unsigned RAND_W       = 12
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [N_PLAYERS-1:0]         stop,
    input  logic                         clear_best,
    input  logic [RAND_W-1:0]            rand_in,
    output logic                         stim_led,
    output logic                         busy,
    output logic [N_PLAYERS*CNT_W-1:0]   times,
    output logic [N_PLAYERS-1:0]         valid,
    output logic [N_PLAYERS-1:0]         cheat,
    output logic [N_PLAYERS-1:0]         slow,
    output logic [2:0]                   winner,
    output logic                         winner_valid,
    output logic [CNT_W-1:0]             best_time
);

    localparam logic [CNT_W-1:0] AllOnes  = ALL_ONES[CNT_W-1:0];
    localparam logic [CNT_W-1:0] MaxCnt   = CNT_W'(MAX_MS);
    localparam logic [CNT_W-1:0] MinDelay = CNT_W'(MIN_DELAY_MS);

    logic tick;

    ms_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk_i (clk),
        .rst_ni(reset_n),
        .tick_o(tick)
    );

    // Two-flop synchronisers plus a delayed copy for rising-edge detection.
    logic                 start_s1_q, start_s2_q, start_prev_q, start_edge;
    logic [N_PLAYERS-1:0] stop_s1_q, stop_s2_q, stop_prev_q, stop_edge;

    assign start_edge = start_s2_q & ~start_prev_q;
    assign stop_edge  = stop_s2_q & ~stop_prev_q;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic [CNT_W-1:0] best_q, best_d;
    logic [CNT_W-1:0] times_q [N_PLAYERS];
    logic [CNT_W-1:0] times_d [N_PLAYERS];
    res_e             res_q   [N_PLAYERS];
    res_e             res_d   [N_PLAYERS];

    logic             all_res;
    logic             win_found;
    logic [2:0]       win_idx;
    logic [CNT_W-1:0] win_time;

    always_comb begin
        all_res = 1'b1;
        for (int p = 0; p < N_PLAYERS; p++) begin
            if (res_q[p] == ResNone) all_res = 1'b0;
        end
    end

    // Strict less-than keeps the lower index on equal times.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_time  = AllOnes;
        for (int p = 0; p < N_PLAYERS; p++) begin
            if (res_q[p] == ResValid && (!win_found || times_q[p] < win_time)) begin
                win_found = 1'b1;
                win_idx   = 3'(p);
                win_time  = times_q[p];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        dcnt_d  = dcnt_q;
        rcnt_d  = rcnt_q;
        best_d  = best_q;
        times_d = times_q;
        res_d   = res_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_edge) begin
                    state_d = StArmed;
                    delay_d = MinDelay + CNT_W'(rand_in);
                    dcnt_d  = '0;
                    for (int p = 0; p < N_PLAYERS; p++) begin
                        res_d[p]   = ResNone;
                        times_d[p] = '0;
                    end
                end
            end
            StArmed: begin
                if (tick) dcnt_d = dcnt_q + CNT_W'(1);
                for (int p = 0; p < N_PLAYERS; p++) begin
                    if (stop_edge[p] && res_q[p] == ResNone) begin
                        res_d[p]   = ResCheat;
                        times_d[p] = AllOnes;
                    end
                end
                if (all_res) begin
                    state_d = StDone;
                end else if (dcnt_q == delay_q) begin
                    state_d = StStim;
                    rcnt_d  = '0;
                end
            end
            StStim: begin
                if (tick && rcnt_q != MaxCnt) rcnt_d = rcnt_q + CNT_W'(1);
                // A stop edge in the timeout cycle beats the slow verdict.
                for (int p = 0; p < N_PLAYERS; p++) begin
                    if (res_q[p] == ResNone) begin
                        if (stop_edge[p]) begin
                            res_d[p]   = ResValid;
                            times_d[p] = rcnt_q;
                        end else if (rcnt_q == MaxCnt) begin
                            res_d[p]   = ResSlow;
                            times_d[p] = MaxCnt;
                        end
                    end
                end
                if (all_res) begin
                    state_d = StDone;
                    if (win_found && win_time < best_q) best_d = win_time;
                end
            end
            default: state_d = StIdle;
        endcase
        if (clear_best) best_d = AllOnes;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_s1_q   <= 1'b0;
            start_s2_q   <= 1'b0;
            start_prev_q <= 1'b0;
            stop_s1_q    <= '0;
            stop_s2_q    <= '0;
            stop_prev_q  <= '0;
            state_q      <= StIdle;
            delay_q      <= '0;
            dcnt_q       <= '0;
            rcnt_q       <= '0;
            best_q       <= AllOnes;
            for (int p = 0; p < N_PLAYERS; p++) begin
                times_q[p] <= '0;
                res_q[p]   <= ResNone;
            end
        end else begin
            start_s1_q   <= start;
            start_s2_q   <= start_s1_q;
            start_prev_q <= start_s2_q;
            stop_s1_q    <= stop;
            stop_s2_q    <= stop_s1_q;
            stop_prev_q  <= stop_s2_q;
            state_q      <= state_d;
            delay_q      <= delay_d;
            dcnt_q       <= dcnt_d;
            rcnt_q       <= rcnt_d;
            best_q       <= best_d;
            times_q      <= times_d;
            res_q        <= res_d;
        end
    end

    assign stim_led     = (state_q == StStim);
    assign busy         = (state_q == StArmed) || (state_q == StStim);
    assign winner       = win_idx;
    assign winner_valid = (state_q == StDone) && win_found;
    assign best_time    = best_q;

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_out
        assign times[g*CNT_W +: CNT_W] = times_q[g];
        assign valid[g] = (res_q[g] == ResValid);
        assign cheat[g] = (res_q[g] == ResCheat);
        assign slow[g]  = (res_q[g] == ResSlow);
    end

endmodule

// File: tb/tb_reaction_timer_nch.sv
module tb_reaction_timer_nch;

    localparam int unsigned NP = 2;
    localparam int unsigned CW = 16;
    localparam int unsigned RW = 12;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [NP-1:0]    stop;
    logic             clear_best;
    logic [RW-1:0]    rand_in;
    logic             stim_led;
    logic             busy;
    logic [NP*CW-1:0] times;
    logic [NP-1:0]    valid;
    logic [NP-1:0]    cheat;
    logic [NP-1:0]    slow;
    logic [2:0]       winner;
    logic             winner_valid;
    logic [CW-1:0]    best_time;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reaction_timer_nch #(
        .N_PLAYERS   (NP),
        .CNT_W       (CW),
        .TICK_DIV    (4),
        .MIN_DELAY_MS(10),
        .MAX_MS      (50),
        .RAND_W      (RW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .clear_best  (clear_best),
        .rand_in     (rand_in),
        .stim_led    (stim_led),
        .busy        (busy),
        .times       (times),
        .valid       (valid),
        .cheat       (cheat),
        .slow        (slow),
        .winner      (winner),
        .winner_valid(winner_valid),
        .best_time   (best_time)
    );

    // {valid, cheat, slow, winner, winner_valid, busy, stim_led}
    function automatic logic [11:0] flags();
        return {valid, cheat, slow, winner, winner_valid, busy, stim_led};
    endfunction

    task automatic press_start();
        @(posedge clk); #1 start = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns the 1-based negedge index at which stim_led was first seen, 0 on timeout.
    task automatic wait_stim(output int n);
        n = 0;
        for (int i = 1; i <= 200 && n == 0; i++) begin
            @(negedge clk);
            if (stim_led) n = i;
        end
        checks++;
        if (n == 0) begin
            errors++;
            $display("FAIL stim_wait: stim_led got 0 want 1 within 200 cycles");
        end
    endtask

    // Stop for player p goes high c cycles after the first STIM cycle (edge acts 2 later);
    // c < 0 means no press. Runs long enough to cover the timeout.
    task automatic run_round(input int c0, input int c1);
        int n;
        wait_stim(n);
        for (int j = 1; j <= 210; j++) begin
            @(posedge clk); #1;
            stop[0] = (c0 >= 0 && j >= c0 && j < c0 + 3);
            stop[1] = (c1 >= 0 && j >= c1 && j < c1 + 3);
        end
        stop = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [11:0] exp;
        exp = 12'b0;
        @(negedge clk);
        checks++;
        if (flags() !== exp) begin
            errors++; $display("FAIL reset_flags: got %b want %b", flags(), exp);
        end
        checks++;
        if (times !== 32'h0) begin
            errors++; $display("FAIL reset_times: got %h want %h", times, 32'h0);
        end
        checks++;
        if (best_time !== 16'hFFFF) begin
            errors++; $display("FAIL reset_best: got %h want %h", best_time, 16'hFFFF);
        end
    endtask

    task automatic test_two_valid();
        logic [11:0] exp;
        press_start();
        run_round(78, 118);
        exp = {2'b11, 2'b00, 2'b00, 3'd0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (flags() !== exp) begin
            errors++; $display("FAIL two_valid_flags: got %b want %b", flags(), exp);
        end
        checks++;
        if (times !== {16'd30, 16'd20}) begin
            errors++; $display("FAIL two_valid_times: got %h want %h", times, {16'd30, 16'd20});
        end
        checks++;
        if (best_time !== 16'd20) begin
            errors++; $display("FAIL two_valid_best: got %0d want 20", best_time);
        end
    endtask

    task automatic test_cheat();
        logic [11:0] exp;
        press_start();
        repeat (5) @(posedge clk);
        #1 stop[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 stop[0] = 1'b0;
        @(negedge clk);
        exp = {2'b00, 2'b01, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0};
        checks++;
        if (flags() !== exp) begin
            errors++; $display("FAIL cheat_armed: got %b want %b", flags(), exp);
        end
        run_round(-1, 46);
        exp = {2'b10, 2'b01, 2'b00, 3'd1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (flags() !== exp) begin
            errors++; $display("FAIL cheat_flags: got %b want %b", flags(), exp);
        end
        checks++;
        if (times !== {16'd12, 16'hFFFF}) begin
            errors++; $display("FAIL cheat_times: got %h want %h", times, {16'd12, 16'hFFFF});
        end
        checks++;
        if (best_time !== 16'd12) begin
            errors++; $display("FAIL cheat_best: got %0d want 12", best_time);
        end
    endtask

    task automatic test_both_cheat();
        logic [11:0] exp;
        logic        seen;
        logic        done;
        seen = 1'b0;
        done = 1'b0;
        press_start();
        repeat (5) @(posedge clk);
        #1 stop = 2'b11;
        repeat (3) @(posedge clk);
        #1 stop = 2'b00;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            seen = seen | stim_led;
            if (!busy) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL both_cheat_done: busy got 1 want 0 within 100 cycles");
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL both_cheat_stim: stim_led seen %b want 0", seen);
        end
        exp = {2'b00, 2'b11, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (flags() !== exp) begin
            errors++; $display("FAIL both_cheat_flags: got %b want %b", flags(), exp);
        end
        checks++;
        if (times !== 32'hFFFF_FFFF || best_time !== 16'd12) begin
            errors++;
            $display("FAIL both_cheat_times: got %h/%h want ffffffff/000c", times, best_time);
        end
    endtask

    task automatic test_timeout();
        logic [11:0] exp;
        press_start();
        run_round(-1, -1);
        exp = {2'b00, 2'b00, 2'b11, 3'd0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (flags() !== exp) begin
            errors++; $display("FAIL timeout_flags: got %b want %b", flags(), exp);
        end
        checks++;
        if (times !== 32'h0032_0032 || best_time !== 16'd12) begin
            errors++; $display("FAIL timeout_times: got %h/%h want 00320032/000c", times, best_time);
        end
        press_start();
        run_round(197, -1);
        exp = {2'b01, 2'b00, 2'b10, 3'd0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (flags() !== exp) begin
            errors++; $display("FAIL timeout_stop_flags: got %b want %b", flags(), exp);
        end
        checks++;
        if (times !== 32'h0032_0032 || best_time !== 16'd12) begin
            errors++;
            $display("FAIL timeout_stop_times: got %h/%h want 00320032/000c", times, best_time);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp;
        press_start();
        run_round(58, 58);
        exp = {2'b11, 2'b00, 2'b00, 3'd0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (flags() !== exp) begin
            errors++; $display("FAIL tie_flags: got %b want %b", flags(), exp);
        end
        checks++;
        if (times !== 32'h000F_000F || best_time !== 16'd12) begin
            errors++; $display("FAIL tie_times: got %h/%h want 000f000f/000c", times, best_time);
        end
        press_start();
        run_round(46, 34);
        exp = {2'b11, 2'b00, 2'b00, 3'd1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (flags() !== exp) begin
            errors++; $display("FAIL best9_flags: got %b want %b", flags(), exp);
        end
        checks++;
        if (times !== 32'h0009_000C || best_time !== 16'd9) begin
            errors++; $display("FAIL best9_times: got %h/%h want 0009000c/0009", times, best_time);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] exp;
        int          n;
        press_start();
        repeat (16) @(posedge clk);
        press_start();
        wait_stim(n);
        checks++;
        if (n < 30 || n > 48) begin
            errors++; $display("FAIL start_ignored: stim after %0d cycles want 30..48", n);
        end
        for (int j = 1; j <= 20; j++) begin
            @(posedge clk); #1;
            stop[0] = (j >= 10 && j < 13);
        end
        @(negedge clk);
        exp = {2'b01, 2'b00, 2'b00, 3'd0, 1'b0, 1'b1, 1'b1};
        checks++;
        if (flags() !== exp) begin
            errors++; $display("FAIL mid_stim_flags: got %b want %b", flags(), exp);
        end
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        checks++;
        if (flags() !== 12'b0 || times !== 32'h0) begin
            errors++; $display("FAIL reset_mid_flags: got %b/%h want 0/0", flags(), times);
        end
        checks++;
        if (best_time !== 16'hFFFF) begin
            errors++; $display("FAIL reset_mid_best: got %h want ffff", best_time);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || stim_led !== 1'b0) begin
            errors++; $display("FAIL reset_mid_idle: busy/stim got %b%b want 00", busy, stim_led);
        end
    endtask

    task automatic test_clear_best();
        logic [11:0] exp;
        press_start();
        run_round(18, -1);
        exp = {2'b01, 2'b00, 2'b10, 3'd0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (flags() !== exp) begin
            errors++; $display("FAIL clear_round_flags: got %b want %b", flags(), exp);
        end
        checks++;
        if (times !== 32'h0032_0005 || best_time !== 16'd5) begin
            errors++; $display("FAIL clear_round_times: got %h/%h want 00320005/0005", times, best_time);
        end
        @(posedge clk); #1 clear_best = 1'b1;
        @(posedge clk); #1 clear_best = 1'b0;
        @(negedge clk);
        checks++;
        if (best_time !== 16'hFFFF) begin
            errors++; $display("FAIL clear_best: got %h want ffff", best_time);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        stop       = '0;
        clear_best = 1'b0;
        rand_in    = 12'd5;
        repeat (3) @(posedge clk);
        test_reset();
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        test_two_valid();
        test_cheat();
        test_both_cheat();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_clear_best();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/reaction_timer_nch.md
REACTION_TIMER_NCH -- requirements
Module: reaction_timer_nch

Interface
REQ-001 Parameter N_PLAYERS, default 2: number of independent stop-button channels, range 1..8.
REQ-002 Parameter CNT_W, default 16: width of every millisecond counter and latched time.
REQ-003 Parameter TICK_DIV, default 100000: clk cycles per 1 ms tick, at least 2.
REQ-004 Parameter MIN_DELAY_MS, default 1000: fixed part of the stimulus delay.
REQ-005 Parameter MAX_MS, default 1000: timeout for responses; must be less than 2^CNT_W-1.
REQ-006 Parameter RAND_W, default 12: width of the random-delay input.
REQ-007 clk  in  1  single system clock; all logic is on its rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  raw start button, asynchronous to clk.
REQ-010 stop  in  N_PLAYERS  raw per-player stop buttons, asynchronous to clk.
REQ-011 clear_best  in  1  synchronous single-cycle pulse that clears the best time.
REQ-012 rand_in  in  RAND_W  free-running random value from an external LFSR.
REQ-013 stim_led  out  1  stimulus LED; high only in state STIM.
REQ-014 busy  out  1  high in states ARMED and STIM.
REQ-015 times  out  N_PLAYERS*CNT_W  latched time per player; player p occupies bits [p*CNT_W +: CNT_W].
REQ-016 valid, cheat, slow  out  N_PLAYERS each  per-player result flags; exactly one flag per player is high in DONE.
REQ-017 winner  out  3  index of the fastest valid player.
REQ-018 winner_valid  out  1  high in DONE when at least one player is valid.
REQ-019 best_time  out  CNT_W  minimum winner time since reset or clear_best.

Function
REQ-020 start and each stop bit shall pass through a 2-flop synchroniser followed by a rising-edge detector; only detected edges act.
REQ-021 Internal tick: a one-cycle pulse every TICK_DIV clk cycles, free-running from reset.
REQ-022 States, in this order: IDLE, ARMED, STIM, DONE.
REQ-023 IDLE or DONE on a start edge -> ARMED on the next clk edge:
- rand_in is captured into delay = MIN_DELAY_MS + rand_in, zero-extended to CNT_W;
- the delay counter is cleared;
- all per-player times and flags are cleared.
REQ-024 start edges shall be ignored in ARMED and STIM.
REQ-025 ARMED: the delay counter increments on each tick; when it equals delay, the state goes to STIM and the response counter is cleared.
REQ-026 ARMED, stop edge on player p: set cheat[p] and latch times[p] = all ones (displayed as 9999). Other players keep waiting.
REQ-027 ARMED, every player has cheated: go to DONE without entering STIM.
REQ-028 STIM: the response counter increments on each tick, saturating at MAX_MS.
REQ-029 STIM, first stop edge from an unresolved player p: latch times[p] = current response count and set valid[p]. Later edges from p, and edges from players that already cheated, are ignored.
REQ-030 STIM, response count reaches MAX_MS: every unresolved player gets slow set and times = MAX_MS.
REQ-031 STIM, all players resolved: go to DONE on the next clk edge.
REQ-032 A stop edge and the timeout in the same cycle: the stop wins, giving valid with time MAX_MS.
REQ-033 winner = lowest-index valid player among those with the minimum time; ties resolve to the lower index.
REQ-034 On entry to DONE with winner_valid set: best_time = min(best_time, winner time).
REQ-035 clear_best sets best_time to all ones; if it coincides with an update, clear_best takes priority.
REQ-036 Outputs shall hold their values in DONE until the next start edge.

Reset
REQ-037 reset_n low shall asynchronously force:
- state IDLE, with all counters, synchronisers and the tick divider cleared;
- stim_led, busy, valid, cheat, slow, winner and winner_valid set to 0;
- times set to 0 and best_time to all ones.
REQ-038 Reset asserted mid-round shall abort the round with no flag or best_time update.

Structure
REQ-039 Package reaction_pkg shall hold the state enum, the per-player result enum (NONE, VALID, CHEAT, SLOW) and a CNT_W-independent ALL_ONES helper constant.
REQ-040 One sub-module, ms_tick_gen, parameterised by TICK_DIV, shall produce the tick; all other logic stays in reaction_timer_nch.

Verification (TICK_DIV=4, MIN_DELAY_MS=10, MAX_MS=50, N_PLAYERS=2)
REQ-041 rand_in=5, start, p0 stops 20 ticks after STIM, p1 stops at 30 -> valid=2'b11, times 20/30, winner=0, best_time=20.
REQ-042 p0 stops during ARMED, p1 stops at 12 -> cheat[0]=1, times[0]=FFFF, valid[1]=1, winner=1.
REQ-043 Both stop during ARMED -> DONE without stim_led ever high, winner_valid=0, best_time unchanged.
REQ-044 No stops -> slow=2'b11, times 50/50; a stop in the MAX_MS cycle instead gives valid with time 50.
REQ-045 Both stop in the same cycle at 15 -> winner=0; a following round at 9 -> best_time=9; then clear_best -> FFFF.
REQ-046 reset_n pulsed during STIM -> all outputs reach reset values immediately; start is ignored during ARMED.
